// File: rtl/costas_pkg.sv
// Shared types and helpers for the Costas receiver blocks: phase/amplitude
// types, quadrant encoding and the quarter-wave sine generator used at elaboration.
package costas_pkg;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_AMP_W   = 16;

  typedef logic [DEF_PHASE_W-1:0]      phase_t;
  typedef logic signed [DEF_AMP_W-1:0] amp_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

  // Sample k of a quarter sine wave, taken at bin centres so every entry is
  // strictly positive and the negated value always fits in the signed range.
  function automatic int qw_sin(int k, int lut_aw, int amp_w);
    real full_scale;
    real ang;
    full_scale = real'((1 << (amp_w - 1)) - 1);
    ang        = 1.5707963267948966 * (real'(k) + 0.5) / real'(1 << lut_aw);
    return $rtoi($floor(full_scale * $sin(ang) + 0.5));
  endfunction

endpackage

// File: rtl/nco_sincos_if.sv
// Sample-stream interface between the loop filter / mixers and the NCO.
interface nco_sincos_if import costas_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int AMP_W   = DEF_AMP_W
) ();

  // Handshake: en is a one-cycle strobe with no ready; every en is accepted
  // and produces exactly one out_valid pulse three cycles later. There is no
  // back-pressure, so the consumer must take each sample when out_valid is high.
  logic                      en;
  logic [PHASE_W-1:0]        freq_ctrl;
  logic                      phase_clr;
  logic signed [AMP_W-1:0]   sin_out;
  logic signed [AMP_W-1:0]   cos_out;
  logic [PHASE_W-1:0]        phase_out;
  logic                      out_valid;

  modport master (
    output en, freq_ctrl, phase_clr,
    input  sin_out, cos_out, phase_out, out_valid
  );

  modport slave (
    input  en, freq_ctrl, phase_clr,
    output sin_out, cos_out, phase_out, out_valid
  );

endinterface

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine ROM with two synchronous read ports; contents are
// computed at elaboration, so there is no load path.
module nco_qw_rom import costas_pkg::*; #(
  parameter int LUT_AW = 10,
  parameter int AMP_W  = DEF_AMP_W
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [LUT_AW-1:0] addr_a_i,
  input  logic [LUT_AW-1:0] addr_b_i,
  output logic [AMP_W-1:0]  data_a_o,
  output logic [AMP_W-1:0]  data_b_o
);

  localparam int DEPTH = 2 ** LUT_AW;

  logic [AMP_W-1:0] rom [DEPTH];
  logic [AMP_W-1:0] data_a_q;
  logic [AMP_W-1:0] data_b_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = AMP_W'(qw_sin(k, LUT_AW, AMP_W));
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      data_a_q <= rom[addr_a_i];
      data_b_q <= rom[addr_b_i];
    end
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/nco_sincos.sv
// Numerically controlled oscillator: 32-bit phase accumulator driving a
// three-stage quarter-wave lookup that emits quadrature sin/cos samples.
module nco_sincos import costas_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW  = 10,
  parameter int AMP_W   = DEF_AMP_W
) (
  input logic         clk,
  input logic         rst,
  nco_sincos_if.slave bus
);

  logic [PHASE_W-1:0]      samp_ph;
  logic [PHASE_W-1:0]      acc_d, acc_q;
  logic [PHASE_W-1:0]      ph1_q, ph2_q, ph3_q;
  quad_t                   q1_q, q2_q;
  logic [LUT_AW-1:0]       a1_q;
  logic                    v1_q, v2_q, v3_q;
  logic signed [AMP_W-1:0] rom_a, rom_b;
  logic signed [AMP_W-1:0] sin_d, cos_d, sin_q, cos_q;

  // A clear coinciding with en restarts the sample itself at phase zero.
  assign samp_ph = bus.phase_clr ? '0 : acc_q;

  always_comb begin
    acc_d = acc_q;
    if (bus.en)             acc_d = samp_ph + bus.freq_ctrl;
    else if (bus.phase_clr) acc_d = '0;
  end

  nco_qw_rom #(.LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_rom (
    .clk      (clk),
    .rd_en_i  (v1_q),
    .addr_a_i (a1_q),
    .addr_b_i (~a1_q),
    .data_a_o (rom_a),
    .data_b_o (rom_b)
  );

  // rom_a = T[a], rom_b = T[~a] (the mirrored quarter).
  always_comb begin
    sin_d = rom_a;
    cos_d = rom_b;
    case (q2_q)
      Q0: begin sin_d =  rom_a; cos_d =  rom_b; end
      Q1: begin sin_d =  rom_b; cos_d = -rom_a; end
      Q2: begin sin_d = -rom_a; cos_d = -rom_b; end
      Q3: begin sin_d = -rom_b; cos_d =  rom_a; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ph1_q <= '0;
      ph2_q <= '0;
      ph3_q <= '0;
      q1_q  <= Q0;
      q2_q  <= Q0;
      a1_q  <= '0;
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      acc_q <= acc_d;
      v1_q  <= bus.en;
      if (bus.en) begin
        ph1_q <= samp_ph;
        q1_q  <= quad_t'(samp_ph[PHASE_W-1 -: 2]);
        a1_q  <= samp_ph[PHASE_W-3 -: LUT_AW];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        ph2_q <= ph1_q;
        q2_q  <= q1_q;
      end
      // Output registers only load on a valid sample so they hold during gaps.
      v3_q <= v2_q;
      if (v2_q) begin
        ph3_q <= ph2_q;
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.phase_out = ph3_q;
  assign bus.out_valid = v3_q;

endmodule

// File: tb/tb_nco_sincos.sv
// Bench for nco_sincos: spec vector table, random stream checked against a
// floating-point sin/cos model, and reset-with-samples-in-flight sequences.
module tb_nco_sincos;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nco_sincos_if bus ();

  nco_sincos dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          en;
    bit          clr;
    logic [31:0] freq;
    logic [31:0] ph;
    logic [15:0] s;
    logic [15:0] c;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_acc;
  logic [2:0]  en_hist = 3'b000;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Full-wave model sampled at the centre of each 12-bit phase bin.
  function automatic logic [15:0] model_amp(logic [31:0] p, bit is_cos);
    real th, v, x;
    th = 6.283185307179586 * (real'(p[31:20]) + 0.5) / 4096.0;
    v  = is_cos ? $cos(th) : $sin(th);
    x  = 32767.0 * v;
    if (x >= 0.0) return 16'($rtoi(x + 0.5));
    else          return 16'(-$rtoi(-x + 0.5));
  endfunction

  function automatic void add(bit en, bit clr, logic [31:0] freq,
                              logic [31:0] ph, int s, int c);
    vec_t v;
    v.en = en; v.clr = clr; v.freq = freq; v.ph = ph;
    v.s = 16'(s); v.c = 16'(c);
    vecs.push_back(v);
  endfunction

  task automatic drive(bit en, bit clr, logic [31:0] freq,
                       bit use_exp, logic [63:0] exp_v);
    logic [31:0] p;
    bus.en        = en;
    bus.phase_clr = clr;
    bus.freq_ctrl = freq;
    p = clr ? 32'h0 : m_acc;
    if (en) begin
      exp_q.push_back(use_exp ? exp_v : {p, model_amp(p, 1'b0), model_amp(p, 1'b1)});
      m_acc = p + freq;
    end else if (clr) begin
      m_acc = 32'h0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, releases with en low.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_sin",   {48'h0, bus.sin_out},   64'h0);
    check("rst_cos",   {48'h0, bus.cos_out},   64'h0);
    check("rst_phase", {32'h0, bus.phase_out}, 64'h0);
    exp_q.delete();
    m_acc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    bus.en        = 1'b0;
    bus.phase_clr = 1'b0;
    rst           = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) en_hist <= 3'b000;
    else     en_hist <= {en_hist[1:0], bus.en};
  end

  // Monitor: valid timing, sample scoreboard, and hold between samples.
  initial begin
    logic [63:0] held, want, got;
    held = 64'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 64'h0;
      end else begin
        got = {bus.phase_out, bus.sin_out, bus.cos_out};
        check("valid_timing", {63'h0, bus.out_valid}, {63'h0, en_hist[2]});
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_sample: got %h, expected no sample (t=%0t)", got, $time);
          end else begin
            want = exp_q.pop_front();
            check("sample", got, want);
            held = want;
          end
        end else begin
          check("hold", got, held);
        end
      end
    end
  end

  initial begin
    int guard;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.phase_clr = 1'b0;
    bus.freq_ctrl = 32'h0;
    m_acc         = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Put non-zero samples on the outputs, then reset with en held high.
    repeat (4) drive(1'b1, 1'b0, 32'h1234_5678, 1'b0, 64'h0);
    idle(3);
    bus.en = 1'b1;
    do_reset();

    // Quarter-turn steps forward.
    add(1, 0, 32'h4000_0000, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'h4000_0000, 32'h4000_0000,  32767,    -25);
    add(1, 0, 32'h4000_0000, 32'h8000_0000,    -25, -32767);
    add(1, 0, 32'h4000_0000, 32'hC000_0000, -32767,     25);
    add(1, 0, 32'h4000_0000, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'h4000_0000, 32'h4000_0000,  32767,    -25);
    add(1, 0, 32'h4000_0000, 32'h8000_0000,    -25, -32767);
    add(1, 0, 32'h4000_0000, 32'hC000_0000, -32767,     25);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    // Quarter-turn steps backward.
    add(1, 0, 32'hC000_0000, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'hC000_0000, 32'hC000_0000, -32767,     25);
    add(1, 0, 32'hC000_0000, 32'h8000_0000,    -25, -32767);
    add(1, 0, 32'hC000_0000, 32'h4000_0000,  32767,    -25);
    // Accumulator wrap through zero.
    add(1, 0, 32'hFFFF_FFF0, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'h0000_0020, 32'hFFFF_FFF0,    -25,  32767);
    add(1, 0, 32'h0000_0020, 32'h0000_0010,     25,  32767);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    // Clear with en, then clear alone, then constant phase.
    add(1, 1, 32'h4000_0000, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'h4000_0000, 32'h4000_0000,  32767,    -25);
    add(0, 1, 32'h0,         32'h0, 0, 0);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    add(1, 0, 32'h0000_0000, 32'h0000_0000,     25,  32767);
    add(1, 0, 32'h0000_0000, 32'h0000_0000,     25,  32767);
    // en with gaps.
    add(1, 0, 32'h4000_0000, 32'h0000_0000,     25,  32767);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    add(1, 0, 32'h4000_0000, 32'h4000_0000,  32767,    -25);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    add(0, 0, 32'h0,         32'h0, 0, 0);
    add(1, 0, 32'h0000_0000, 32'h8000_0000,    -25, -32767);

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].en, vecs[i].clr, vecs[i].freq, 1'b1,
            {vecs[i].ph, vecs[i].s, vecs[i].c});
    idle(4);

    // Random stream against the model.
    repeat (200)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            32'($urandom), 1'b0, 64'h0);
    idle(4);

    // Reset with two samples in flight: nothing may emerge afterwards.
    drive(1'b1, 1'b0, 32'h0100_0000, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 32'h0100_0000, 1'b0, 64'h0);
    do_reset();
    idle(8);

    // Restart after reset and drain.
    repeat (5) drive(1'b1, 1'b0, 32'h3000_0000, 1'b0, 64'h0);
    bus.en = 1'b0;
    guard  = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d samples still pending, expected 0", exp_q.size());
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
